bin_to_bcd_seq: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 29 ++
 rtl/bcd_add3.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 144 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: state codes,
// default widths, the saturation limit and the bit-counter width.
package bin2bcd_pkg;

    localparam int unsigned IN_W_DEF   = 14;
    localparam int unsigned DIGITS_DEF = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Largest decimal value representable in the given number of digits.
    function automatic int unsigned max_dec(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned in_w);
        return 32'($clog2(in_w + 1));
    endfunction

    localparam int unsigned MAX_DEC = max_dec(DIGITS_DEF);
    localparam int unsigned CNT_W   = cnt_w(IN_W_DEF);

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: nibbles of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib_c
);

    assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with saturation to all 9s.
// Optional macro BIN2BCD_AUTO_CONVERT_EN: restart automatically when bin_in changes.
module bin_to_bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned IN_W   = IN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [3:0]      d3,
    output logic [3:0]      d2,
    output logic [3:0]      d1,
    output logic [3:0]      d0
);

    localparam int unsigned     BCD_W  = 4 * DIGITS;
    localparam int unsigned     CW     = cnt_w(IN_W);
    localparam logic [IN_W-1:0] MAX_IN = IN_W'(max_dec(DIGITS));

    logic [1:0]       r_state,    w_state_nx;
    logic [IN_W-1:0]  r_bin,      w_bin_nx;
    logic [BCD_W-1:0] r_bcd,      w_bcd_nx;
    logic [CW-1:0]    r_cnt,      w_cnt_nx;
    logic             r_ovf_pend, w_ovf_pend_nx;
    logic             r_busy,     w_busy_nx;
    logic             r_done,     w_done_nx;
    logic             r_ovf,      w_ovf_nx;
    logic [BCD_W-1:0] r_dig,      w_dig_nx;
    logic [BCD_W-1:0] w_adj;
    logic             w_go;

`ifdef BIN2BCD_AUTO_CONVERT_EN
    logic [IN_W-1:0]  r_last_bin, w_last_bin_nx;
    assign w_go = start || (bin_in != r_last_bin);
`else
    assign w_go = start;
`endif

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_nib   (r_bcd[4*g +: 4]),
                .o_nib_c (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // Next-state, datapath and registered-output logic.
    always_comb begin
        w_state_nx    = r_state;
        w_bin_nx      = r_bin;
        w_bcd_nx      = r_bcd;
        w_cnt_nx      = r_cnt;
        w_ovf_pend_nx = r_ovf_pend;
        w_busy_nx     = r_busy;
        w_done_nx     = 1'b0;
        w_ovf_nx      = r_ovf;
        w_dig_nx      = r_dig;
`ifdef BIN2BCD_AUTO_CONVERT_EN
        w_last_bin_nx = r_last_bin;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nx    = S_SHIFT;
                    w_bin_nx      = bin_in;
                    w_bcd_nx      = '0;
                    w_cnt_nx      = CW'(IN_W);
                    w_ovf_pend_nx = (bin_in > MAX_IN);
                    w_busy_nx     = 1'b1;
`ifdef BIN2BCD_AUTO_CONVERT_EN
                    w_last_bin_nx = bin_in;
`endif
                end
            end
            S_SHIFT: begin
                {w_bcd_nx, w_bin_nx} = {w_adj[BCD_W-2:0], r_bin, 1'b0};
                // A carry out of the top digit can only occur for out-of-range values.
                w_ovf_pend_nx = r_ovf_pend | w_adj[BCD_W-1];
                w_cnt_nx      = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nx = S_DONE;
                    w_done_nx  = 1'b1;
                    w_ovf_nx   = w_ovf_pend_nx;
                    w_dig_nx   = w_ovf_pend_nx ? {DIGITS{4'h9}} : w_bcd_nx;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_dig      <= '0;
`ifdef BIN2BCD_AUTO_CONVERT_EN
            r_last_bin <= '0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_bin      <= w_bin_nx;
            r_bcd      <= w_bcd_nx;
            r_cnt      <= w_cnt_nx;
            r_ovf_pend <= w_ovf_pend_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
            r_ovf      <= w_ovf_nx;
            r_dig      <= w_dig_nx;
`ifdef BIN2BCD_AUTO_CONVERT_EN
            r_last_bin <= w_last_bin_nx;
`endif
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_ovf;
    assign d3       = r_dig[15:12];
    assign d2       = r_dig[11:8];
    assign d1       = r_dig[7:4];
    assign d0       = r_dig[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (latency, exact values,
// saturation, start handling and asynchronous reset).
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  d3, d2, d1, d0;

    int total;
    int bad;

    bin_to_bcd_seq u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .d3       (d3),
        .d2       (d2),
        .d1       (d1),
        .d0       (d0)
    );

    always #5 clk = ~clk;

    // Launch one conversion and wait (bounded) for its done pulse.
    task automatic run_conv(input logic [13:0] v, output int lat,
                            output logic [15:0] dig, output logic ovf);
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        dig = '0;
        ovf = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                dig = {d3, d2, d1, d0};
                ovf = overflow;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, overflow} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000", {busy, done, overflow});
        end
        total++;
        if ({d3, d2, d1, d0} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_digits: got %h want 0000", {d3, d2, d1, d0});
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset busy: got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        @(negedge clk);
        bin_in = 14'd1234;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy_rise: got %b want 1", busy);
        end
        if (done) lat = 1;
        for (int c = 2; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (done) lat = c;
        end
        total++;
        if (lat != 15) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 15", lat);
        end
        total++;
        if ({d3, d2, d1, d0, overflow} !== {16'h1234, 1'b0}) begin
            bad++;
            $display("FAIL basic_result: got %h ovf %b want 1234 ovf 0",
                     {d3, d2, d1, d0}, overflow);
        end
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL basic_after_done busy/done: got %b want 00", {busy, done});
        end
    endtask

    task automatic test_values();
        logic [13:0] vals [6];
        logic [15:0] exp_d [6];
        logic        exp_o [6];
        int          lat;
        logic [15:0] dig;
        logic        ovf;
        vals[0] = 14'd0;     exp_d[0] = 16'h0000; exp_o[0] = 1'b0;
        vals[1] = 14'd9999;  exp_d[1] = 16'h9999; exp_o[1] = 1'b0;
        vals[2] = 14'd10;    exp_d[2] = 16'h0010; exp_o[2] = 1'b0;
        vals[3] = 14'd10000; exp_d[3] = 16'h9999; exp_o[3] = 1'b1;
        vals[4] = 14'd16383; exp_d[4] = 16'h9999; exp_o[4] = 1'b1;
        vals[5] = 14'd42;    exp_d[5] = 16'h0042; exp_o[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_conv(vals[i], lat, dig, ovf);
            total++;
            if (lat != 15) begin
                bad++;
                $display("FAIL value_%0d latency: got %0d want 15", vals[i], lat);
            end
            total++;
            if (dig !== exp_d[i]) begin
                bad++;
                $display("FAIL value_%0d digits: got %h want %h", vals[i], dig, exp_d[i]);
            end
            total++;
            if (ovf !== exp_o[i]) begin
                bad++;
                $display("FAIL value_%0d overflow: got %b want %b", vals[i], ovf, exp_o[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int          pulses;
        int          first_c;
        int          second_c;
        logic [15:0] first_d;
        logic [15:0] second_d;
        logic        second_o;
        pulses   = 0;
        first_c  = -1;
        second_c = -1;
        first_d  = '0;
        second_d = '0;
        second_o = 1'b1;
        @(negedge clk);
        bin_in = 14'd1234;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first_c < 0) begin
                    first_c = c;
                    first_d = {d3, d2, d1, d0};
                end else begin
                    second_c = c;
                    second_d = {d3, d2, d1, d0};
                    second_o = overflow;
                end
            end
            if (c == 8) begin
                total++;
                if ({d3, d2, d1, d0} !== 16'h0042) begin
                    bad++;
                    $display("FAIL hold_during_shift: got %h want 0042", {d3, d2, d1, d0});
                end
            end
            if (c == 20) begin
                total++;
                if ({d3, d2, d1, d0} !== 16'h1234) begin
                    bad++;
                    $display("FAIL hold_during_second: got %h want 1234", {d3, d2, d1, d0});
                end
            end
            if (c == 4) begin
                bin_in = 14'd5678;
                start  = 1'b1;
            end
            if (c == 5)  start = 1'b0;
            if (c == 12) start = 1'b1;
            if (c == 17) start = 1'b0;
        end
        total++;
        if (first_c != 15 || first_d !== 16'h1234) begin
            bad++;
            $display("FAIL ignore_first: got cyc %0d dig %h want cyc 15 dig 1234",
                     first_c, first_d);
        end
        total++;
        if (second_c != 31 || second_d !== 16'h5678 || second_o !== 1'b0) begin
            bad++;
            $display("FAIL held_start_second: got cyc %0d dig %h ovf %b want cyc 31 dig 5678 ovf 0",
                     second_c, second_d, second_o);
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL ignore_pulse_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_async_reset();
        int          pulses;
        int          lat;
        logic [15:0] dig;
        logic        ovf;
        @(negedge clk);
        bin_in = 14'd8191;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL areset_busy_before: got %b want 1", busy);
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({busy, done, overflow} !== 3'b000 || {d3, d2, d1, d0} !== 16'h0000) begin
            bad++;
            $display("FAIL areset_immediate: got flags %b dig %h want 000 0000",
                     {busy, done, overflow}, {d3, d2, d1, d0});
        end
        bin_in = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL areset_no_done: got %0d pulses want 0", pulses);
        end
        run_conv(14'd8191, lat, dig, ovf);
        total++;
        if (lat != 15 || dig !== 16'h8191 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL areset_reconvert: got lat %0d dig %h ovf %b want 15 8191 0",
                     lat, dig, ovf);
        end
    endtask

`ifdef BIN2BCD_AUTO_CONVERT_EN
    task automatic test_auto();
        int          lat;
        int          pulses;
        logic [15:0] dig;
        @(negedge clk);
        bin_in = '0;
        repeat (25) @(negedge clk);
        bin_in = 14'd255;
        lat = -1;
        dig = '0;
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                dig = {d3, d2, d1, d0};
            end
        end
        total++;
        if (lat < 0 || lat > 16 || dig !== 16'h0255) begin
            bad++;
            $display("FAIL auto_convert: got lat %0d dig %h want <=16 0255", lat, dig);
        end
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL auto_steady: got %0d pulses want 0", pulses);
        end
    endtask
`endif

    initial begin
        clk    = 1'b0;
        resetn = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        total  = 0;
        bad    = 0;
        test_reset();
        test_basic();
        test_values();
        test_ignore_start();
        test_async_reset();
`ifdef BIN2BCD_AUTO_CONVERT_EN
        test_auto();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
